// File: rtl/sram_arbiter.sv
// sram_arbiter: sequences CPU byte reads/writes and video reads onto an
// 8-bit asynchronous SRAM with programmable read/write wait states, a
// write-to-read turnaround gap and alternating priority when both sources
// contend. All SRAM pins and handshake outputs come straight from flops.
module sram_arbiter #(
  parameter int ADDR_W  = 21,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  parameter int TURN    = 1
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_CNT  = CNT_W'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] TRN_CNT = CNT_W'(TURN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    TRN
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              pend_valid;
  logic              pend_wr;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_wdata;
  logic              last_vid;

  logic cpu_strobe;
  logic vid_live;
  logic grant_vid;
  logic grant_cpu;
  logic take_cpu;
  logic cpu_end;

  // A video request is treated as already served during its ack cycle, so a
  // requester that drops vid_req one cycle late is not granted twice.
  assign cpu_strobe = (cpu_rd | cpu_wr) & ~cpu_busy;
  assign vid_live   = vid_req & ~vid_ack;
  assign grant_vid  = vid_live & (~pend_valid | ~last_vid);
  assign grant_cpu  = pend_valid & ~grant_vid;
  assign take_cpu   = (state == IDLE) & grant_cpu;
  assign cpu_end    = ((state == RD) | (state == WR)) & (cnt == '0) & ~last_vid;

  // One-deep CPU request slot: loaded by an accepted strobe, emptied on grant;
  // busy covers both the pending and the in-flight phase.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      pend_valid <= 1'b0;
      pend_wr    <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      cpu_busy   <= 1'b0;
    end else begin
      if (cpu_strobe) begin
        pend_valid <= 1'b1;
        pend_wr    <= cpu_wr;
        pend_addr  <= cpu_addr;
        pend_wdata <= cpu_wdata;
      end else if (take_cpu) begin
        pend_valid <= 1'b0;
      end
      if (cpu_strobe) begin
        cpu_busy <= 1'b1;
      end else if (cpu_end) begin
        cpu_busy <= 1'b0;
      end
    end
  end

  // Access sequencer: arbitrates in IDLE, then drives the SRAM pins for the
  // programmed number of wait cycles and returns data / completion pulses.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state      <= IDLE;
      cnt        <= '0;
      last_vid   <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      cpu_rdata  <= '0;
      vid_data   <= '0;
      cpu_done   <= 1'b0;
      vid_ack    <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      vid_ack  <= 1'b0;
      case (state)
        IDLE: begin
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          if (grant_vid) begin
            sram_addr <= vid_addr;
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            cnt       <= RD_CNT;
            last_vid  <= 1'b1;
            state     <= RD;
          end else if (grant_cpu) begin
            sram_addr <= pend_addr;
            sram_ce_n <= 1'b0;
            last_vid  <= 1'b0;
            if (pend_wr) begin
              sram_dq_o  <= pend_wdata;
              sram_dq_oe <= 1'b1;
              sram_we_n  <= 1'b0;
              cnt        <= WR_CNT;
              state      <= WR;
            end else begin
              sram_oe_n <= 1'b0;
              cnt       <= RD_CNT;
              state     <= RD;
            end
          end
        end
        RD: begin
          if (cnt == '0) begin
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            if (last_vid) begin
              vid_data <= sram_dq_i;
              vid_ack  <= 1'b1;
            end else begin
              cpu_rdata <= sram_dq_i;
              cpu_done  <= 1'b1;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        WR: begin
          if (cnt == '0) begin
            sram_ce_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            cpu_done   <= 1'b1;
            if (TURN > 0) begin
              cnt   <= TRN_CNT;
              state <= TRN;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        TRN: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: drives sram_arbiter against a behavioural async SRAM,
// keeps a reference memory and expected-read queues, and compares CPU/video
// read data, pin timing and grant order scenario by scenario.
module tb_sram_arbiter;

  localparam logic [20:0] VID_A = 21'h00200;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [20:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic        vid_req = 1'b0;
  logic [20:0] vid_addr = VID_A;
  logic [7:0]  vid_data;
  logic        vid_ack;
  logic [20:0] sram_addr;
  logic [7:0]  sram_dq_o;
  logic        sram_dq_oe;
  logic [7:0]  sram_dq_i = '0;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] sram_mem [logic [20:0]];
  logic [7:0] ref_mem  [logic [20:0]];
  logic [7:0] exp_cpu_q [$];
  logic [7:0] exp_vid_q [$];
  bit         grant_log [$];
  logic [7:0] last_exp_rdata = '0;

  int oe_low_cnt = 0;
  int we_low_cnt = 0;
  int both_low_cnt = 0;
  int dq_bad_cnt = 0;
  int vid_ack_cnt = 0;
  bit prev_ce_n = 1'b1;

  always #5 clk = ~clk;

  sram_arbiter #(
    .ADDR_W(21), .DATA_W(8), .RD_WAIT(2), .WR_WAIT(2), .TURN(1)
  ) dut (
    .clk(clk), .resetq(resetq),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_ack(vid_ack),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  function automatic logic [7:0] dev_rd(input logic [20:0] a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [20:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 8'h00;
  endfunction

  // Behavioural SRAM plus pin activity counters, evaluated mid-cycle.
  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram_mem[sram_addr] = sram_dq_o;
    if (!sram_oe_n) oe_low_cnt++;
    if (!sram_we_n) we_low_cnt++;
    if (!sram_oe_n && !sram_we_n) both_low_cnt++;
    if (sram_dq_oe && sram_we_n) dq_bad_cnt++;
    if (vid_ack) vid_ack_cnt++;
    if (prev_ce_n && !sram_ce_n) grant_log.push_back(sram_addr == VID_A);
    prev_ce_n = sram_ce_n;
    if (!sram_ce_n && !sram_oe_n) sram_dq_i = dev_rd(sram_addr);
    else sram_dq_i = 8'h00;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [20:0] a, input logic [7:0] d);
    sram_mem[a] = d;
    ref_mem[a]  = d;
  endtask

  task automatic issue_cpu(input bit rd, input bit wr, input logic [20:0] a, input logic [7:0] d);
    cpu_rd = rd;
    cpu_wr = wr;
    cpu_addr = a;
    cpu_wdata = d;
    if (wr) ref_mem[a] = d;
    else if (rd) exp_cpu_q.push_back(ref_rd(a));
    tick();
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  task automatic wait_cpu_done(input int budget, output int cycles, output bit seen);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      tick();
      cycles++;
      if (cpu_done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    resetq = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
      tests_failed++;
      $display("[TB] FAIL reset_pins: got %b required 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
    end
    tests_run++;
    if ({cpu_busy, cpu_done, vid_ack} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b required 000", {cpu_busy, cpu_done, vid_ack});
    end
    tests_run++;
    if ({sram_addr, sram_dq_o, cpu_rdata, vid_data} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: addr %h dq_o %h rdata %h vdata %h required all 0",
               sram_addr, sram_dq_o, cpu_rdata, vid_data);
    end
    resetq = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read();
    int gcyc;
    int dcyc;
    bit seen;
    logic [7:0] exp;
    oe_low_cnt = 0;
    issue_cpu(1'b1, 1'b0, 21'h00010, 8'h00);
    tests_run++;
    if (cpu_busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rd_busy_rise: got %b required 1", cpu_busy);
    end
    gcyc = 0;
    while (sram_oe_n && gcyc < 4) begin
      tick();
      gcyc++;
    end
    tests_run++;
    if (gcyc !== 1) begin
      tests_failed++;
      $display("[TB] FAIL rd_grant_delay: got %0d cycles required 1", gcyc);
    end
    wait_cpu_done(10, dcyc, seen);
    tests_run++;
    if (!seen || dcyc !== 2) begin
      tests_failed++;
      $display("[TB] FAIL rd_latency: got %0d cycles (seen %b) required 2", dcyc, seen);
    end
    exp = exp_cpu_q.pop_front();
    tests_run++;
    if (cpu_rdata !== exp) begin
      tests_failed++;
      $display("[TB] FAIL rd_data: got %h required %h", cpu_rdata, exp);
    end
    tests_run++;
    if (cpu_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rd_busy_fall: got %b required 0", cpu_busy);
    end
    tests_run++;
    if (oe_low_cnt !== 2) begin
      tests_failed++;
      $display("[TB] FAIL rd_oe_width: got %0d cycles required 2", oe_low_cnt);
    end
    tick();
  endtask

  task automatic test_write_turn();
    int wcyc;
    int dcyc;
    bit seen;
    logic [7:0] exp;
    oe_low_cnt = 0;
    we_low_cnt = 0;
    dq_bad_cnt = 0;
    issue_cpu(1'b0, 1'b1, 21'h1FFFFF, 8'h3C);
    wcyc = 0;
    while (sram_we_n && wcyc < 4) begin
      tick();
      wcyc++;
    end
    vid_addr = VID_A;
    vid_req = 1'b1;
    exp_vid_q.push_back(ref_rd(VID_A));
    wait_cpu_done(10, dcyc, seen);
    tests_run++;
    if (!seen || we_low_cnt !== 2 || oe_low_cnt !== 0) begin
      tests_failed++;
      $display("[TB] FAIL wr_we_width: we_low %0d oe_low %0d seen %b required 2,0,1", we_low_cnt, oe_low_cnt, seen);
    end
    tests_run++;
    if (dq_bad_cnt !== 0 || sram_dq_oe !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wr_dq_oe: stray cycles %0d dq_oe %b required 0,0", dq_bad_cnt, sram_dq_oe);
    end
    tick();
    tests_run++;
    if (sram_ce_n !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL wr_turnaround: ce_n got %b required 1", sram_ce_n);
    end
    tick();
    tests_run++;
    if ({sram_ce_n, sram_oe_n} !== 2'b00 || sram_addr !== VID_A) begin
      tests_failed++;
      $display("[TB] FAIL wr_next_grant: ce_n/oe_n %b addr %h required 00 %h", {sram_ce_n, sram_oe_n}, sram_addr, VID_A);
    end
    wcyc = 0;
    while (!vid_ack && wcyc < 6) begin
      tick();
      wcyc++;
    end
    vid_req = 1'b0;
    exp = exp_vid_q.pop_front();
    tests_run++;
    if (!vid_ack || vid_data !== exp) begin
      tests_failed++;
      $display("[TB] FAIL wr_vid_data: ack %b data %h required 1 %h", vid_ack, vid_data, exp);
    end
    issue_cpu(1'b1, 1'b0, 21'h1FFFFF, 8'h00);
    wait_cpu_done(10, dcyc, seen);
    exp = exp_cpu_q.pop_front();
    tests_run++;
    if (!seen || cpu_rdata !== exp) begin
      tests_failed++;
      $display("[TB] FAIL wr_readback: got %h (seen %b) required %h", cpu_rdata, seen, exp);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int k;
    int vid_acks;
    int cpu_at;
    int vid_grants;
    bit cpu_seen;
    logic [7:0] exp;
    grant_log.delete();
    both_low_cnt = 0;
    vid_ack_cnt = 0;
    vid_addr = VID_A;
    vid_req = 1'b1;
    exp_vid_q.push_back(ref_rd(VID_A));
    issue_cpu(1'b1, 1'b0, 21'h00300, 8'h00);
    k = 0;
    vid_acks = 0;
    cpu_at = 0;
    cpu_seen = 1'b0;
    while (!(vid_acks == 2 && cpu_seen) && k < 40) begin
      tick();
      k++;
      if (vid_ack) begin
        vid_acks++;
        tests_run++;
        if (exp_vid_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL b2b_vid_extra: got unexpected vid_ack data %h required none", vid_data);
        end else begin
          exp = exp_vid_q.pop_front();
          if (vid_data !== exp) begin
            tests_failed++;
            $display("[TB] FAIL b2b_vid_data: got %h required %h", vid_data, exp);
          end
        end
        if (vid_acks == 2) vid_req = 1'b0;
        else exp_vid_q.push_back(ref_rd(VID_A));
      end
      if (cpu_done) begin
        cpu_seen = 1'b1;
        cpu_at = k;
        exp = exp_cpu_q.pop_front();
        tests_run++;
        if (cpu_rdata !== exp) begin
          tests_failed++;
          $display("[TB] FAIL b2b_cpu_data: got %h required %h", cpu_rdata, exp);
        end
      end
    end
    repeat (4) tick();
    tests_run++;
    if (!cpu_seen || cpu_at !== 5) begin
      tests_failed++;
      $display("[TB] FAIL b2b_cpu_latency: got %0d cycles (seen %b) required 5", cpu_at, cpu_seen);
    end
    tests_run++;
    if (grant_log.size() !== 3 || grant_log[0] !== 1'b1 || grant_log[1] !== 1'b0 || grant_log[2] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_grant_order: got %0d grants %p required vid,cpu,vid", grant_log.size(), grant_log);
    end
    vid_grants = 0;
    foreach (grant_log[i]) if (grant_log[i]) vid_grants++;
    tests_run++;
    if (vid_ack_cnt !== vid_grants || vid_ack_cnt !== 2) begin
      tests_failed++;
      $display("[TB] FAIL b2b_ack_count: got %0d acks for %0d video grants required 2", vid_ack_cnt, vid_grants);
    end
    tests_run++;
    if (both_low_cnt !== 0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_oe_we_overlap: got %0d cycles required 0", both_low_cnt);
    end
  endtask

  task automatic test_busy_drop();
    int dcyc;
    int extra;
    bit seen;
    logic [7:0] exp;
    issue_cpu(1'b1, 1'b0, 21'h00410, 8'h00);
    cpu_wr = 1'b1;
    cpu_addr = 21'h00400;
    cpu_wdata = 8'hEE;
    tick();
    cpu_wr = 1'b0;
    wait_cpu_done(10, dcyc, seen);
    exp = exp_cpu_q.pop_front();
    tests_run++;
    if (!seen || cpu_rdata !== exp) begin
      tests_failed++;
      $display("[TB] FAIL drop_rd_data: got %h (seen %b) required %h", cpu_rdata, seen, exp);
    end
    extra = 0;
    repeat (8) begin
      tick();
      if (cpu_done) extra++;
    end
    tests_run++;
    if (extra !== 0 || cpu_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL drop_done_count: extra dones %0d busy %b required 0,0", extra, cpu_busy);
    end
    tests_run++;
    if (dev_rd(21'h00400) !== ref_rd(21'h00400)) begin
      tests_failed++;
      $display("[TB] FAIL drop_mem: got %h required %h", dev_rd(21'h00400), ref_rd(21'h00400));
    end
  endtask

  task automatic test_reset_abort();
    int wcyc;
    int dcyc;
    int pulses;
    bit seen;
    logic [7:0] exp;
    issue_cpu(1'b1, 1'b0, 21'h00600, 8'h00);
    wcyc = 0;
    while (sram_oe_n && wcyc < 4) begin
      tick();
      wcyc++;
    end
    tick();
    #2;
    resetq = 1'b0;
    #1;
    tests_run++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, cpu_busy} !== 5'b11100) begin
      tests_failed++;
      $display("[TB] FAIL abort_pins: got %b required 11100", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, cpu_busy});
    end
    exp_cpu_q.delete();
    repeat (2) tick();
    resetq = 1'b1;
    pulses = 0;
    repeat (6) begin
      tick();
      if (cpu_done || vid_ack) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("[TB] FAIL abort_no_done: got %0d pulses required 0", pulses);
    end
    issue_cpu(1'b1, 1'b0, 21'h00700, 8'h00);
    wait_cpu_done(10, dcyc, seen);
    exp = exp_cpu_q.pop_front();
    last_exp_rdata = exp;
    tests_run++;
    if (!seen || cpu_rdata !== exp) begin
      tests_failed++;
      $display("[TB] FAIL abort_recover: got %h (seen %b) required %h", cpu_rdata, seen, exp);
    end
    tick();
  endtask

  task automatic test_rd_wr_same();
    int dcyc;
    bit seen;
    we_low_cnt = 0;
    issue_cpu(1'b1, 1'b1, 21'h00500, 8'h5A);
    wait_cpu_done(10, dcyc, seen);
    repeat (2) tick();
    tests_run++;
    if (!seen || we_low_cnt !== 2 || dev_rd(21'h00500) !== ref_rd(21'h00500)) begin
      tests_failed++;
      $display("[TB] FAIL both_write: mem %h we_low %0d seen %b required %h 2 1",
               dev_rd(21'h00500), we_low_cnt, seen, ref_rd(21'h00500));
    end
    tests_run++;
    if (cpu_rdata !== last_exp_rdata) begin
      tests_failed++;
      $display("[TB] FAIL both_rdata_kept: got %h required %h", cpu_rdata, last_exp_rdata);
    end
  endtask

  initial begin
    preload(21'h00010, 8'hA5);
    preload(VID_A,     8'h77);
    preload(21'h00300, 8'h99);
    preload(21'h00400, 8'h22);
    preload(21'h00410, 8'h11);
    preload(21'h00600, 8'h42);
    preload(21'h00700, 8'h81);
    test_reset();
    test_cpu_read();
    test_write_turn();
    test_back_to_back();
    test_busy_drop();
    test_reset_abort();
    test_rd_wr_same();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
